// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forward-select codes, GPR width, Tnew helper.
package pipe_pkg;

    localparam int unsigned GPR_AW   = 5;
    localparam int unsigned FWD_NONE = 0;
    localparam int unsigned SAT_W    = 8;

    // Select code that picks the link address (PC + offset)
    function automatic int unsigned fwd_pc_code(input int unsigned num_src);
        return num_src + 1;
    endfunction

    // Saturating decrement; callers cast to their own Tnew width (<= SAT_W)
    function automatic logic [SAT_W-1:0] sat_dec(input logic [SAT_W-1:0] x);
        return (x == '0) ? '0 : (x - SAT_W'(1));
    endfunction

endpackage

// File: rtl/stage_fwd_reg_if.sv
// Stage register bus: upstream fields in, registered fields and forward bus out.
interface stage_fwd_reg_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned TNEW_W  = 2
);
    import pipe_pkg::*;

    localparam int unsigned SEL_W = $clog2(NUM_SRC + 2);

    logic                      en;
    logic                      flush;
    logic                      valid_in;
    logic [DATA_W-1:0]         pc_in;
    logic [DATA_W-1:0]         instr_in;
    logic [GPR_AW-1:0]         dst_in;
    logic [TNEW_W-1:0]         tnew_in;
    logic [SEL_W-1:0]          fwd_sel_in;
    logic [NUM_SRC*DATA_W-1:0] src_in;

    logic [DATA_W-1:0]         pc_out;
    logic [DATA_W-1:0]         instr_out;
    logic [NUM_SRC*DATA_W-1:0] src_out;
    logic                      valid_out;
    logic [GPR_AW-1:0]         dst_out;
    logic [TNEW_W-1:0]         tnew_out;
    logic [DATA_W-1:0]         fwd_data;
    logic [GPR_AW-1:0]         fwd_dst;
    logic                      fwd_ready;

    modport master (
        output en, flush, valid_in, pc_in, instr_in, dst_in, tnew_in, fwd_sel_in, src_in,
        input  pc_out, instr_out, src_out, valid_out, dst_out, tnew_out,
               fwd_data, fwd_dst, fwd_ready
    );

    modport slave (
        input  en, flush, valid_in, pc_in, instr_in, dst_in, tnew_in, fwd_sel_in, src_in,
        output pc_out, instr_out, src_out, valid_out, dst_out, tnew_out,
               fwd_data, fwd_dst, fwd_ready
    );

endinterface

// File: rtl/stage_fwd_reg_mux.sv
// Forward-source selector: none, one payload channel, or PC + offset.
module fwd_src_mux
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 3,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PC_OFFSET = 8
) (
    input  logic [$clog2(NUM_SRC+2)-1:0] i_sel,
    input  logic [NUM_SRC*DATA_W-1:0]    i_src,
    input  logic [DATA_W-1:0]            i_pc,
    output logic [DATA_W-1:0]            o_data
);
    localparam int unsigned SEL_W = $clog2(NUM_SRC + 2);

    // Decode select; unused codes (0 and above the PC code) yield zero
    always_comb begin
        o_data = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data = i_src[(k-1)*DATA_W +: DATA_W];
            end
        end
        if (i_sel == SEL_W'(fwd_pc_code(NUM_SRC))) begin
            o_data = i_pc + DATA_W'(PC_OFFSET);
        end
    end

endmodule

// File: rtl/stage_fwd_reg.sv
// Inter-stage pipeline register with stall/flush, Tnew countdown and a qualified forward bus.
module stage_fwd_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_SRC   = 3,
    parameter int unsigned TNEW_W    = 2,
    parameter int unsigned PC_OFFSET = 8
) (
    input  logic            clk,
    input  logic            reset,
    stage_fwd_reg_if.slave  bus
);
    localparam int unsigned SEL_W = $clog2(NUM_SRC + 2);

    logic                      r_valid;
    logic [DATA_W-1:0]         r_pc;
    logic [DATA_W-1:0]         r_instr;
    logic [GPR_AW-1:0]         r_dst;
    logic [TNEW_W-1:0]         r_tnew;
    logic [SEL_W-1:0]          r_sel;
    logic [NUM_SRC*DATA_W-1:0] r_src;

    logic [TNEW_W-1:0]         w_tnew_nxt;
    logic                      w_ready;
    logic [DATA_W-1:0]         w_fwd_data;

    // Tnew counts down from the new value on load, or in place while stalled
    always_comb begin
        w_tnew_nxt = TNEW_W'(sat_dec(SAT_W'(bus.en ? bus.tnew_in : r_tnew)));
    end

    // Field registers: flush beats load beats hold; a bubble keeps its PC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
            r_dst   <= '0;
            r_tnew  <= '0;
            r_sel   <= '0;
            r_src   <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_pc    <= bus.pc_in;
            r_instr <= '0;
            r_dst   <= '0;
            r_tnew  <= '0;
            r_sel   <= '0;
            r_src   <= '0;
        end else if (bus.en) begin
            r_valid <= bus.valid_in;
            r_pc    <= bus.pc_in;
            r_instr <= bus.instr_in;
            r_dst   <= bus.dst_in;
            r_tnew  <= w_tnew_nxt;
            r_sel   <= bus.fwd_sel_in;
            r_src   <= bus.src_in;
        end else begin
            r_tnew  <= w_tnew_nxt;
        end
    end

    fwd_src_mux #(
        .NUM_SRC   (NUM_SRC),
        .DATA_W    (DATA_W),
        .PC_OFFSET (PC_OFFSET)
    ) u_mux (
        .i_sel  (r_sel),
        .i_src  (r_src),
        .i_pc   (r_pc),
        .o_data (w_fwd_data)
    );

    // Forward is usable only for a real producer with a final, selected result
    always_comb begin
        w_ready = r_valid && (r_dst != '0) && (r_tnew == '0) && (r_sel != SEL_W'(FWD_NONE));
    end

    assign bus.valid_out = r_valid;
    assign bus.pc_out    = r_pc;
    assign bus.instr_out = r_instr;
    assign bus.dst_out   = r_dst;
    assign bus.tnew_out  = r_tnew;
    assign bus.src_out   = r_src;
    assign bus.fwd_data  = w_fwd_data;
    assign bus.fwd_dst   = w_ready ? r_dst : '0;
    assign bus.fwd_ready = w_ready;

endmodule

// File: tb/tb_stage_fwd_reg.sv
// Bench for stage_fwd_reg: behavioural field model checked every cycle plus directed literals.
module tb_stage_fwd_reg;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    stage_fwd_reg_if #(.DATA_W(32), .NUM_SRC(3), .TNEW_W(2)) bus ();

    stage_fwd_reg #(.DATA_W(32), .NUM_SRC(3), .TNEW_W(2), .PC_OFFSET(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state as plain values
    int          m_valid = 0;
    logic [31:0] m_pc    = 0;
    logic [31:0] m_instr = 0;
    int          m_dst   = 0;
    int          m_tnew  = 0;
    int          m_sel   = 0;
    logic [31:0] m_src [3] = '{default: 32'h0};

    function automatic int dec_sat(input int x);
        return (x > 0) ? x - 1 : 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid = 0; m_pc = 0; m_instr = 0; m_dst = 0; m_tnew = 0; m_sel = 0;
            for (int i = 0; i < 3; i++) m_src[i] = 0;
        end else if (bus.flush) begin
            m_valid = 0; m_pc = bus.pc_in; m_instr = 0; m_dst = 0; m_tnew = 0; m_sel = 0;
            for (int i = 0; i < 3; i++) m_src[i] = 0;
        end else if (bus.en) begin
            m_valid = int'(bus.valid_in);
            m_pc    = bus.pc_in;
            m_instr = bus.instr_in;
            m_dst   = int'(bus.dst_in);
            m_tnew  = dec_sat(int'(bus.tnew_in));
            m_sel   = int'(bus.fwd_sel_in);
            for (int i = 0; i < 3; i++) m_src[i] = bus.src_in[i*32 +: 32];
        end else begin
            m_tnew = dec_sat(m_tnew);
        end
    end

    function automatic logic [31:0] exp_data();
        if (m_sel >= 1 && m_sel <= 3) return m_src[m_sel-1];
        if (m_sel == 4) return m_pc + 32'd8;
        return 32'h0;
    endfunction

    function automatic int exp_ready();
        return (m_valid != 0 && m_dst != 0 && m_tnew == 0 && m_sel != 0) ? 1 : 0;
    endfunction

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        chk("valid_out", 32'(bus.valid_out), 32'(m_valid));
        chk("pc_out",    bus.pc_out,          m_pc);
        chk("instr_out", bus.instr_out,       m_instr);
        chk("dst_out",   32'(bus.dst_out),    32'(m_dst));
        chk("tnew_out",  32'(bus.tnew_out),   32'(m_tnew));
        for (int i = 0; i < 3; i++) chk("src_out", bus.src_out[i*32 +: 32], m_src[i]);
        chk("fwd_data",  bus.fwd_data,        exp_data());
        chk("fwd_ready", 32'(bus.fwd_ready),  32'(exp_ready()));
        chk("fwd_dst",   32'(bus.fwd_dst),    (exp_ready() != 0) ? 32'(m_dst) : 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic en, input logic fl, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic [4:0] dst, input logic [1:0] tn,
                         input logic [2:0] sel, input logic [31:0] s0, input logic [31:0] s1,
                         input logic [31:0] s2);
        bus.en = en; bus.flush = fl; bus.valid_in = v; bus.pc_in = pc; bus.instr_in = ins;
        bus.dst_in = dst; bus.tnew_in = tn; bus.fwd_sel_in = sel; bus.src_in = {s2, s1, s0};
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        tick();
        chk("rst valid_out", 32'(bus.valid_out), 32'h0);
        chk("rst fwd_ready", 32'(bus.fwd_ready), 32'h0);
        chk("rst pc_out",    bus.pc_out,         32'h0);
        reset = 1'b1;

        // Link-address forward, result ready immediately
        drive(1, 0, 1, 32'h3000, 32'h0C000123, 5'd5, 2'd0, 3'd4, 32'h11, 32'h22, 32'h33);
        tick();
        chk("load fwd_data",  bus.fwd_data,         32'h3008);
        chk("load fwd_dst",   32'(bus.fwd_dst),     32'd5);
        chk("load fwd_ready", 32'(bus.fwd_ready),   32'h1);

        // Countdown under stall
        drive(1, 0, 1, 32'h3004, 32'h8C450000, 5'd7, 2'd2, 3'd1, 32'hDEADBEEF, 32'h1, 32'h2);
        tick();
        chk("cd tnew1",  32'(bus.tnew_out),  32'd1);
        chk("cd ready0", 32'(bus.fwd_ready), 32'h0);
        drive(0, 0, 1, 32'h9999, 32'h0, 5'd1, 2'd3, 3'd2, 32'h0, 32'h0, 32'h0);
        tick();
        chk("cd tnew0",  32'(bus.tnew_out),  32'd0);
        chk("cd ready1", 32'(bus.fwd_ready), 32'h1);
        chk("cd data",   bus.fwd_data,       32'hDEADBEEF);
        chk("cd pc",     bus.pc_out,         32'h3004);
        chk("cd dst",    32'(bus.dst_out),   32'd7);

        // Flush while stalled
        drive(0, 1, 1, 32'h3010, 32'hFFFF, 5'd9, 2'd1, 3'd1, 32'h5, 32'h6, 32'h7);
        tick();
        chk("fl valid", 32'(bus.valid_out), 32'h0);
        chk("fl instr", bus.instr_out,      32'h0);
        chk("fl dst",   32'(bus.dst_out),   32'h0);
        chk("fl pc",    bus.pc_out,         32'h3010);
        chk("fl ready", 32'(bus.fwd_ready), 32'h0);

        // Register zero and bubble suppression
        drive(1, 0, 1, 32'h3014, 32'h1, 5'd0, 2'd0, 3'd2, 32'h0, 32'hCAFE, 32'h0);
        tick();
        chk("r0 ready",  32'(bus.fwd_ready), 32'h0);
        chk("r0 fwddst", 32'(bus.fwd_dst),   32'h0);
        drive(1, 0, 0, 32'h3018, 32'h2, 5'd9, 2'd0, 3'd2, 32'h0, 32'hCAFE, 32'h0);
        tick();
        chk("bub ready",  32'(bus.fwd_ready), 32'h0);
        chk("bub fwddst", 32'(bus.fwd_dst),   32'h0);
        chk("bub dstout", 32'(bus.dst_out),   32'd9);

        // Select range and PC wrap
        drive(1, 0, 1, 32'h301C, 32'h3, 5'd3, 2'd0, 3'd5, 32'hA, 32'hB, 32'hC);
        tick();
        chk("sel5 data", bus.fwd_data, 32'h0);
        drive(1, 0, 1, 32'hFFFFFFFC, 32'h4, 5'd3, 2'd0, 3'd4, 32'hA, 32'hB, 32'hC);
        tick();
        chk("wrap data", bus.fwd_data, 32'h00000004);

        // Max Tnew saturates at zero after three edges
        drive(1, 0, 1, 32'h3020, 32'h5, 5'd4, 2'd3, 3'd3, 32'h0, 32'h0, 32'h77);
        tick();
        chk("sat t2", 32'(bus.tnew_out), 32'd2);
        bus.en = 1'b0;
        tick();
        tick();
        chk("sat t0", 32'(bus.tnew_out), 32'd0);
        tick();
        chk("sat hold0", 32'(bus.tnew_out), 32'd0);
        chk("sat data",  bus.fwd_data,      32'h77);

        // Mid-cycle async reset with state loaded
        #1 reset = 1'b0;
        #1;
        chk("ar pc",    bus.pc_out,         32'h0);
        chk("ar valid", 32'(bus.valid_out), 32'h0);
        chk("ar ready", 32'(bus.fwd_ready), 32'h0);
        chk("ar data",  bus.fwd_data,       32'h0);
        drive(1, 0, 1, 32'h4000, 32'h6, 5'd2, 2'd0, 3'd1, 32'h55, 32'h0, 32'h0);
        tick();
        chk("ar held", bus.pc_out, 32'h0);
        reset = 1'b1;
        tick();
        chk("ar rel pc", bus.pc_out, 32'h4000);

        // Mixed vectors checked by the per-cycle model compare
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  $urandom, $urandom, $urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
